// File: rtl/hazard_unit_mdu.sv
// Hazard detection and forwarding unit for the five-stage pipeline.
// Resolves RAW hazards via execute- and decode-stage forwarding, interlocks
// load-use, early-branch and multiply/divide-unit dependencies, tracks the
// multi-cycle MDU occupancy and counts stall cycles with a saturating counter.
module hazard_unit_mdu #(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_LATENCY = 4,
  parameter int DECODE_FWD  = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_D,
  input  logic [REG_ADDR_W-1:0] rt_D,
  input  logic [REG_ADDR_W-1:0] rs_E,
  input  logic [REG_ADDR_W-1:0] rt_E,
  input  logic [REG_ADDR_W-1:0] write_reg_E,
  input  logic [REG_ADDR_W-1:0] write_reg_M,
  input  logic [REG_ADDR_W-1:0] write_reg_W,
  input  logic                  reg_write_E,
  input  logic                  reg_write_M,
  input  logic                  reg_write_W,
  input  logic                  mem_to_reg_E,
  input  logic                  mem_to_reg_M,
  input  logic                  branch_D,
  input  logic                  mdu_use_D,
  input  logic                  mdu_start_E,
  output logic                  stall_F,
  output logic                  stall_D,
  output logic                  flush_E,
  output logic [1:0]            forward_A_E,
  output logic [1:0]            forward_B_E,
  output logic                  forward_A_D,
  output logic                  forward_B_D,
  output logic                  mdu_busy,
  output logic                  mdu_overlap_err,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic {
    IDLE,
    BUSY
  } mdu_state_t;

  // Value loaded into the down-counter so that BUSY lasts MDU_LATENCY cycles.
  localparam logic [3:0] LAT_LAST = 4'(MDU_LATENCY - 1);

  mdu_state_t       state;
  mdu_state_t       state_next;
  logic [3:0]       cnt;
  logic [3:0]       cnt_next;
  logic             err_next;
  logic             lwstall;
  logic             brstall;
  logic             mdustall;
  logic             stall;

  // A producer index matches a consumer index only when both agree and the
  // index is not the hard-wired zero register.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] dst,
                                   input logic [REG_ADDR_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  // Classify the three interlock sources and merge them into one stall.
  always_comb begin
    lwstall  = mem_to_reg_E &&
               (reg_hit(write_reg_E, rs_D) || reg_hit(write_reg_E, rt_D));
    brstall  = branch_D &&
               ((reg_write_E  && (reg_hit(write_reg_E, rs_D) || reg_hit(write_reg_E, rt_D))) ||
                (mem_to_reg_M && (reg_hit(write_reg_M, rs_D) || reg_hit(write_reg_M, rt_D))));
    mdustall = mdu_use_D && (mdu_busy || mdu_start_E);
    stall    = !reset && (lwstall || brstall || mdustall);
  end

  // Drive the pipeline control outputs and the forwarding selects; the
  // memory stage wins over writeback because it holds the younger result.
  always_comb begin
    stall_F     = stall;
    stall_D     = stall;
    flush_E     = stall;
    forward_A_E = 2'b00;
    forward_B_E = 2'b00;
    forward_A_D = 1'b0;
    forward_B_D = 1'b0;
    if (!reset) begin
      if (reg_write_M && reg_hit(write_reg_M, rs_E)) begin
        forward_A_E = 2'b10;
      end else if (reg_write_W && reg_hit(write_reg_W, rs_E)) begin
        forward_A_E = 2'b01;
      end
      if (reg_write_M && reg_hit(write_reg_M, rt_E)) begin
        forward_B_E = 2'b10;
      end else if (reg_write_W && reg_hit(write_reg_W, rt_E)) begin
        forward_B_E = 2'b01;
      end
      forward_A_D = (DECODE_FWD != 0) && reg_write_M && reg_hit(write_reg_M, rs_D);
      forward_B_D = (DECODE_FWD != 0) && reg_write_M && reg_hit(write_reg_M, rt_D);
    end
  end

  // MDU occupancy: a start while busy is dropped and flagged, never restarts.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = mdu_overlap_err;
    case (state)
      IDLE: begin
        if (mdu_start_E) begin
          state_next = BUSY;
          cnt_next   = LAT_LAST;
        end
      end
      BUSY: begin
        if (mdu_start_E) begin
          err_next = 1'b1;
        end
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // MDU state register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      mdu_overlap_err <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      mdu_overlap_err <= err_next;
    end
  end

  assign mdu_busy = (state == BUSY);

  // Stall-cycle performance counter, pinned at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mdu.sv
// Self-checking bench for hazard_unit_mdu: a default instance, one with
// decode forwarding disabled and one with a 3-bit stall counter share stimulus.
module tb_hazard_unit_mdu;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] wr_e;
    logic [4:0] wr_m;
    logic [4:0] wr_w;
    logic       rw_e;
    logic       rw_m;
    logic       rw_w;
    logic       m2r_e;
    logic       m2r_m;
    logic       br_d;
    logic       use_d;
    logic       start_e;
  } in_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  fa_e;
    logic [1:0]  fb_e;
    logic        fa_d;
    logic        fb_d;
    logic        busy;
    logic        err;
    logic [15:0] cnt;
    logic [2:0]  cnt3;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W;
  logic       reg_write_E, reg_write_M, reg_write_W;
  logic       mem_to_reg_E, mem_to_reg_M, branch_D, mdu_use_D, mdu_start_E;

  logic        stall_F, stall_D, flush_E, forward_A_D, forward_B_D, mdu_busy, mdu_overlap_err;
  logic [1:0]  forward_A_E, forward_B_E;
  logic [15:0] stall_count;

  logic        nf_stall_F, nf_stall_D, nf_flush_E, nf_forward_A_D, nf_forward_B_D, nf_mdu_busy, nf_err;
  logic [1:0]  nf_forward_A_E, nf_forward_B_E;
  logic [15:0] nf_stall_count;

  logic        c3_stall_F, c3_stall_D, c3_flush_E, c3_forward_A_D, c3_forward_B_D, c3_mdu_busy, c3_err;
  logic [1:0]  c3_forward_A_E, c3_forward_B_E;
  logic [2:0]  c3_stall_count;

  int   n_vectors     = 0;
  int   n_miscompares = 0;
  int   step_no       = 0;
  exp_t sb[$];
  vec_t tbl[11];

  hazard_unit_mdu u_dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
    .write_reg_E(write_reg_E), .write_reg_M(write_reg_M), .write_reg_W(write_reg_W),
    .reg_write_E(reg_write_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
    .mem_to_reg_E(mem_to_reg_E), .mem_to_reg_M(mem_to_reg_M), .branch_D(branch_D),
    .mdu_use_D(mdu_use_D), .mdu_start_E(mdu_start_E),
    .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E),
    .forward_A_E(forward_A_E), .forward_B_E(forward_B_E),
    .forward_A_D(forward_A_D), .forward_B_D(forward_B_D),
    .mdu_busy(mdu_busy), .mdu_overlap_err(mdu_overlap_err), .stall_count(stall_count)
  );

  hazard_unit_mdu #(.DECODE_FWD(0)) u_nf (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
    .write_reg_E(write_reg_E), .write_reg_M(write_reg_M), .write_reg_W(write_reg_W),
    .reg_write_E(reg_write_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
    .mem_to_reg_E(mem_to_reg_E), .mem_to_reg_M(mem_to_reg_M), .branch_D(branch_D),
    .mdu_use_D(mdu_use_D), .mdu_start_E(mdu_start_E),
    .stall_F(nf_stall_F), .stall_D(nf_stall_D), .flush_E(nf_flush_E),
    .forward_A_E(nf_forward_A_E), .forward_B_E(nf_forward_B_E),
    .forward_A_D(nf_forward_A_D), .forward_B_D(nf_forward_B_D),
    .mdu_busy(nf_mdu_busy), .mdu_overlap_err(nf_err), .stall_count(nf_stall_count)
  );

  hazard_unit_mdu #(.CNT_W(3)) u_c3 (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
    .write_reg_E(write_reg_E), .write_reg_M(write_reg_M), .write_reg_W(write_reg_W),
    .reg_write_E(reg_write_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
    .mem_to_reg_E(mem_to_reg_E), .mem_to_reg_M(mem_to_reg_M), .branch_D(branch_D),
    .mdu_use_D(mdu_use_D), .mdu_start_E(mdu_start_E),
    .stall_F(c3_stall_F), .stall_D(c3_stall_D), .flush_E(c3_flush_E),
    .forward_A_E(c3_forward_A_E), .forward_B_E(c3_forward_B_E),
    .forward_A_D(c3_forward_A_D), .forward_B_D(c3_forward_B_D),
    .mdu_busy(c3_mdu_busy), .mdu_overlap_err(c3_err), .stall_count(c3_stall_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_vectors++;
    if (act !== exp_v) begin
      n_miscompares++;
      $display("[TB] FAIL %s at step %0d: got %0h, expected %0h", name, step_no, act, exp_v);
    end
  endfunction

  function automatic vec_t mkv(input in_t i, input exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset        = v.i.rst;
    rs_D         = v.i.rs_d;
    rt_D         = v.i.rt_d;
    rs_E         = v.i.rs_e;
    rt_E         = v.i.rt_e;
    write_reg_E  = v.i.wr_e;
    write_reg_M  = v.i.wr_m;
    write_reg_W  = v.i.wr_w;
    reg_write_E  = v.i.rw_e;
    reg_write_M  = v.i.rw_m;
    reg_write_W  = v.i.rw_w;
    mem_to_reg_E = v.i.m2r_e;
    mem_to_reg_M = v.i.m2r_m;
    branch_D     = v.i.br_d;
    mdu_use_D    = v.i.use_d;
    mdu_start_E  = v.i.start_e;
    step_no++;
    sb.push_back(v.e);
  endtask

  // Combinational outputs are sampled mid-cycle, registered ones just after the edge.
  task automatic checkOutput();
    exp_t e;
    #2;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk("stall_F/D/flush_E", {13'd0, stall_F, stall_D, flush_E}, {13'd0, {3{e.stall}}});
      chk("forward_A_E", {14'd0, forward_A_E}, {14'd0, e.fa_e});
      chk("forward_B_E", {14'd0, forward_B_E}, {14'd0, e.fb_e});
      chk("forward_A_D", {15'd0, forward_A_D}, {15'd0, e.fa_d});
      chk("forward_B_D", {15'd0, forward_B_D}, {15'd0, e.fb_d});
      chk("nf_stalls", {13'd0, nf_stall_F, nf_stall_D, nf_flush_E}, {13'd0, {3{e.stall}}});
      chk("nf_forward_E", {12'd0, nf_forward_A_E, nf_forward_B_E}, {12'd0, e.fa_e, e.fb_e});
      chk("nf_forward_D", {14'd0, nf_forward_A_D, nf_forward_B_D}, 16'd0);
      chk("c3_stalls", {13'd0, c3_stall_F, c3_stall_D, c3_flush_E}, {13'd0, {3{e.stall}}});
      chk("c3_forward", {10'd0, c3_forward_A_E, c3_forward_B_E, c3_forward_A_D, c3_forward_B_D},
          {10'd0, e.fa_e, e.fb_e, e.fa_d, e.fb_d});
      @(posedge clk);
      #1;
      chk("mdu_busy", {15'd0, mdu_busy}, {15'd0, e.busy});
      chk("mdu_overlap_err", {15'd0, mdu_overlap_err}, {15'd0, e.err});
      chk("stall_count", stall_count, e.cnt);
      chk("nf_mdu", {14'd0, nf_mdu_busy, nf_err}, {14'd0, e.busy, e.err});
      chk("nf_stall_count", nf_stall_count, e.cnt);
      chk("c3_mdu", {14'd0, c3_mdu_busy, c3_err}, {14'd0, e.busy, e.err});
      chk("c3_stall_count", {13'd0, c3_stall_count}, {13'd0, e.cnt3});
    end
  endtask

  task automatic run(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  // Main sequence: forwarding/stall table, then MDU and saturation corner cases.
  initial begin
    tbl[0]  = mkv(in_t'{rst:1'b1, rs_e:5'd3, rw_m:1'b1, wr_m:5'd3, rw_w:1'b1, wr_w:5'd3,
                        m2r_e:1'b1, wr_e:5'd5, rt_d:5'd5, default:'0},
                  exp_t'{default:'0});
    tbl[1]  = mkv(in_t'{rw_m:1'b1, wr_m:5'd3, rw_w:1'b1, wr_w:5'd3, rs_e:5'd3, default:'0},
                  exp_t'{fa_e:2'b10, default:'0});
    tbl[2]  = mkv(in_t'{wr_m:5'd3, rw_w:1'b1, wr_w:5'd3, rs_e:5'd3, default:'0},
                  exp_t'{fa_e:2'b01, default:'0});
    tbl[3]  = mkv(in_t'{rs_e:5'd4, rt_e:5'd6, rw_m:1'b1, wr_m:5'd6, rw_w:1'b1, wr_w:5'd4,
                        rs_d:5'd6, rt_d:5'd4, default:'0},
                  exp_t'{fa_e:2'b01, fb_e:2'b10, fa_d:1'b1, default:'0});
    tbl[4]  = mkv(in_t'{rw_m:1'b1, rw_w:1'b1, rw_e:1'b1, m2r_e:1'b1, m2r_m:1'b1, br_d:1'b1, default:'0},
                  exp_t'{default:'0});
    tbl[5]  = mkv(in_t'{m2r_e:1'b1, rw_e:1'b1, wr_e:5'd5, rt_d:5'd5, default:'0},
                  exp_t'{stall:1'b1, cnt:16'd1, cnt3:3'd1, default:'0});
    tbl[6]  = mkv(in_t'{default:'0},
                  exp_t'{cnt:16'd1, cnt3:3'd1, default:'0});
    tbl[7]  = mkv(in_t'{br_d:1'b1, rs_d:5'd7, rw_e:1'b1, wr_e:5'd7, default:'0},
                  exp_t'{stall:1'b1, cnt:16'd2, cnt3:3'd2, default:'0});
    tbl[8]  = mkv(in_t'{br_d:1'b1, rs_d:5'd7, rt_d:5'd7, rw_m:1'b1, wr_m:5'd7, default:'0},
                  exp_t'{fa_d:1'b1, fb_d:1'b1, cnt:16'd2, cnt3:3'd2, default:'0});
    tbl[9]  = mkv(in_t'{br_d:1'b1, rs_d:5'd7, rw_m:1'b1, m2r_m:1'b1, wr_m:5'd7, default:'0},
                  exp_t'{stall:1'b1, fa_d:1'b1, cnt:16'd3, cnt3:3'd3, default:'0});
    tbl[10] = mkv(in_t'{br_d:1'b1, use_d:1'b1, m2r_e:1'b1, rw_e:1'b1, wr_e:5'd9, rs_d:5'd9, default:'0},
                  exp_t'{stall:1'b1, cnt:16'd4, cnt3:3'd4, default:'0});

    $display("[TB] forwarding and stall table");
    for (int k = 0; k < 11; k++) begin
      run(tbl[k]);
    end

    $display("[TB] MDU busy window with dependent decode instruction");
    run(mkv(in_t'{rst:1'b1, default:'0}, exp_t'{default:'0}));
    run(mkv(in_t'{start_e:1'b1, use_d:1'b1, default:'0},
            exp_t'{stall:1'b1, busy:1'b1, cnt:16'd1, cnt3:3'd1, default:'0}));
    for (int k = 2; k <= 4; k++) begin
      run(mkv(in_t'{use_d:1'b1, default:'0},
              exp_t'{stall:1'b1, busy:1'b1, cnt:16'(k), cnt3:3'(k), default:'0}));
    end
    run(mkv(in_t'{use_d:1'b1, default:'0}, exp_t'{stall:1'b1, cnt:16'd5, cnt3:3'd5, default:'0}));
    run(mkv(in_t'{use_d:1'b1, default:'0}, exp_t'{cnt:16'd5, cnt3:3'd5, default:'0}));

    $display("[TB] overlapping start and reset during busy");
    run(mkv(in_t'{start_e:1'b1, default:'0}, exp_t'{busy:1'b1, cnt:16'd5, cnt3:3'd5, default:'0}));
    run(mkv(in_t'{default:'0}, exp_t'{busy:1'b1, cnt:16'd5, cnt3:3'd5, default:'0}));
    run(mkv(in_t'{start_e:1'b1, default:'0}, exp_t'{busy:1'b1, err:1'b1, cnt:16'd5, cnt3:3'd5, default:'0}));
    run(mkv(in_t'{default:'0}, exp_t'{busy:1'b1, err:1'b1, cnt:16'd5, cnt3:3'd5, default:'0}));
    run(mkv(in_t'{default:'0}, exp_t'{err:1'b1, cnt:16'd5, cnt3:3'd5, default:'0}));
    run(mkv(in_t'{default:'0}, exp_t'{err:1'b1, cnt:16'd5, cnt3:3'd5, default:'0}));
    run(mkv(in_t'{start_e:1'b1, default:'0}, exp_t'{busy:1'b1, err:1'b1, cnt:16'd5, cnt3:3'd5, default:'0}));
    run(mkv(in_t'{rst:1'b1, use_d:1'b1, default:'0}, exp_t'{default:'0}));
    run(mkv(in_t'{default:'0}, exp_t'{default:'0}));

    $display("[TB] start coinciding with completion");
    run(mkv(in_t'{start_e:1'b1, default:'0}, exp_t'{busy:1'b1, default:'0}));
    for (int k = 0; k < 3; k++) begin
      run(mkv(in_t'{default:'0}, exp_t'{busy:1'b1, default:'0}));
    end
    run(mkv(in_t'{start_e:1'b1, default:'0}, exp_t'{err:1'b1, default:'0}));
    run(mkv(in_t'{default:'0}, exp_t'{err:1'b1, default:'0}));

    $display("[TB] stall counter saturation");
    for (int k = 1; k <= 10; k++) begin
      run(mkv(in_t'{m2r_e:1'b1, wr_e:5'd5, rt_d:5'd5, default:'0},
              exp_t'{stall:1'b1, err:1'b1, cnt:16'(k), cnt3:((k > 7) ? 3'd7 : 3'(k)), default:'0}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mdu.md
Name: hazard_unit_mdu

Overview:
Parametrised hazard detection and forwarding unit for the five-stage pipeline, the next generation of the fixed 5-bit/2-way forwarding logic. It adds:
- decode-stage forwarding for early branch comparison;
- a multi-cycle multiply/divide unit (MDU) busy tracker with an interlock;
- a saturating stall-cycle performance counter.

It sits beside the datapath. It consumes register indices and control bits from D/E/M/W and drives stall_F, stall_D, flush_E and the forwarding selects.

Parameters:
REG_ADDR_W, 5, register index width
MDU_LATENCY, 4, cycles the MDU stays busy after a start (legal range 1..15)
DECODE_FWD, 1, 1 enables forward_A_D/forward_B_D; 0 ties them low
CNT_W, 16, stall counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
rs_D  in  REG_ADDR_W  decode source A
rt_D  in  REG_ADDR_W  decode source B
rs_E  in  REG_ADDR_W  execute source A
rt_E  in  REG_ADDR_W  execute source B
write_reg_E  in  REG_ADDR_W  execute destination
write_reg_M  in  REG_ADDR_W  memory destination
write_reg_W  in  REG_ADDR_W  writeback destination
reg_write_E  in  1  execute writes register file
reg_write_M  in  1  memory writes register file
reg_write_W  in  1  writeback writes register file
mem_to_reg_E  in  1  execute instruction is a load
mem_to_reg_M  in  1  memory instruction is a load
branch_D  in  1  decode instruction is a branch
mdu_use_D  in  1  decode instruction starts an MDU op or reads HI/LO
mdu_start_E  in  1  execute instruction starts an MDU op
stall_F  out  1  hold PC
stall_D  out  1  hold IF/ID register
flush_E  out  1  bubble the ID/EX register
forward_A_E  out  2  ALU A select
forward_B_E  out  2  ALU B select
forward_A_D  out  1  branch comparator A from M
forward_B_D  out  1  branch comparator B from M
mdu_busy  out  1  MDU in flight
mdu_overlap_err  out  1  sticky: start received while busy
stall_count  out  CNT_W  stall cycles since reset

Behaviour:
- Register index 0 never matches for forwarding or stalls.
- forward_X_E (X = A with rs_E, X = B with rt_E):
  - 2'b10 if reg_write_M and write_reg_M == src;
  - else 2'b01 if reg_write_W and write_reg_W == src;
  - else 2'b00.
  - M has priority over W when both match.
- forward_X_D = DECODE_FWD and reg_write_M and write_reg_M == src (rs_D / rt_D).
- lwstall = mem_to_reg_E and write_reg_E matches rs_D or rt_D.
- brstall = branch_D and one of:
  - reg_write_E and write_reg_E matches rs_D or rt_D;
  - mem_to_reg_M and write_reg_M matches rs_D or rt_D.
- mdustall = mdu_use_D and (mdu_busy or mdu_start_E).
- stall = lwstall | brstall | mdustall. stall_F = stall_D = flush_E = stall. All hazard and forwarding outputs are combinational, zero latency.
- MDU FSM, states IDLE and BUSY, with a 4-bit down-counter cnt:
  - IDLE + mdu_start_E: go to BUSY, cnt = MDU_LATENCY-1.
  - BUSY with cnt != 0: cnt decrements.
  - BUSY with cnt == 0: go to IDLE.
  - mdu_busy = (state == BUSY). It is high for exactly MDU_LATENCY cycles, starting the cycle after the start.
  - mdu_start_E while BUSY: ignored (no restart), mdu_overlap_err set. It stays set until reset.
- stall_count: registered. Increments on every cycle where stall == 1 and reset == 0. It saturates at all-ones with no wrap.
- Reset, synchronous. While reset is high:
  - stall_F, stall_D, flush_E, forward_* are forced to 0;
  - on the next edge, FSM goes to IDLE, cnt = 0, mdu_busy = 0, mdu_overlap_err = 0, stall_count = 0.
  - Reset during BUSY aborts the op; mdu_busy is low after that edge.
- Simultaneous events:
  - lwstall, brstall and mdustall may coincide; there is still a single stall, and stall_count increments by 1.
  - An MDU completion edge and a new mdu_start_E in the same cycle: the counter reaches 0 and the FSM goes to IDLE. The start is ignored, since it arrived while busy, and mdu_overlap_err is set.

Test Plan:
1. reg_write_M=1, write_reg_M=3, reg_write_W=1, write_reg_W=3, rs_E=3, rt_E=0 -> forward_A_E=2'b10, forward_B_E=2'b00. Then drop reg_write_M -> forward_A_E=2'b01.
2. Load-use: mem_to_reg_E=1, write_reg_E=5, rt_D=5 -> stall_F=stall_D=flush_E=1; stall_count goes 0->1 at the next edge. Same stimulus with write_reg_E=0 -> no stall.
3. Branch hazards:
   - branch_D=1, rs_D=7, reg_write_E=1, write_reg_E=7 -> stall=1.
   - Next cycle: write_reg_M=7, reg_write_M=1, mem_to_reg_M=0, E clear -> stall=0, forward_A_D=1.
   - With DECODE_FWD=0 -> forward_A_D=0.
4. MDU with MDU_LATENCY=4: pulse mdu_start_E for 1 cycle -> mdu_busy high for exactly 4 cycles. Holding mdu_use_D=1 during that window -> stall=1 on those 4 cycles plus the start cycle; stall_count=5.
5. mdu_start_E pulsed in the 2nd busy cycle -> mdu_overlap_err=1 and stays high; busy still ends after the original 4 cycles. Reset during BUSY -> busy=0, err=0, stall_count=0 after the edge.
6. CNT_W=3, stall held high for 10 cycles -> stall_count reaches 7 and holds (no wrap to 0).
